// File: rtl/dram_window_reader_if.sv
// dram_window_reader_if
//   Bundles the command, DRAM read-port and output-stream signals of one
//   dram_window_reader instance.
//   master : the reader (drives rd_addr/rd_ena and the output stream)
//   slave  : the environment (command source, DRAM buffer, stream sink)
//   Command : start, base_addr, len, abort ; status busy, done
//   DRAM    : rd_addr, rd_ena -> ; <- q, dval
//   Stream  : out_data, out_valid, out_last -> ; <- out_ready
interface dram_window_reader_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] len;
    logic          abort;
    logic [AW-1:0] rd_addr;
    logic          rd_ena;
    logic [DW-1:0] q;
    logic          dval;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          done;

    modport master (
        input  start, base_addr, len, abort, q, dval, out_ready,
        output rd_addr, rd_ena, out_data, out_valid, out_last, busy, done
    );

    modport slave (
        output start, base_addr, len, abort, q, dval, out_ready,
        input  rd_addr, rd_ena, out_data, out_valid, out_last, busy, done
    );
endinterface

// File: rtl/dram_window_reader.sv
// dram_window_reader
//   Read-side master for the dual-read DRAM buffer. A start command sweeps
//   len words from base_addr (address wraps modulo 2^AW), buffers the read
//   data in a small FIFO and presents it as a valid/ready stream, flagging
//   the final word with out_last. A done pulse closes each sweep, whether
//   it completed, was aborted, or was empty (len == 0).
//   Ports:
//     clk, rst_n : single clock, asynchronous active-low reset
//     bus        : dram_window_reader_if.master (command, DRAM port, stream)
module dram_window_reader #(
    parameter int AW    = 16,
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dram_window_reader_if.master  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t        state;
    logic [AW-1:0] addr;
    logic [AW-1:0] remaining;
    logic          inflight;       // read issued last cycle, data due now
    logic          inflight_last;  // tag of that read: it was the window's final word
    logic          busy_q;
    logic          done_q;

    logic [DW:0]   mem [DEPTH];    // {last_tag, data}
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          active;
    logic [CW:0]   credit_used;
    logic          rd_go;
    logic          push;
    logic          pop;
    logic          drain_done;

    assign active      = (state == READ) || (state == DRAIN);
    // Words already buffered plus the one still in flight must leave room,
    // so a returning dval always finds a free FIFO slot.
    assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign rd_go       = (state == READ) && (credit_used < DEPTH_C);
    assign push        = bus.dval && active;
    assign pop         = bus.out_valid && bus.out_ready;
    // No read outstanding and the FIFO empties with this cycle's pop.
    assign drain_done  = (state == DRAIN) && !inflight && (count == CW'(pop));

    assign bus.rd_addr   = addr;
    assign bus.rd_ena    = rd_go;
    assign bus.out_valid = (count != '0);
    assign bus.out_data  = mem[rd_ptr][DW-1:0];
    assign bus.out_last  = mem[rd_ptr][DW];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            addr          <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            done_q   <= 1'b0;
            inflight <= rd_go;

            if (rd_go) begin
                inflight_last <= (remaining == AW'(1));
                addr          <= addr + AW'(1);
                remaining     <= remaining - AW'(1);
            end

            if (push) begin
                mem[wr_ptr] <= {inflight_last, bus.q};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);

            case (state)
                IDLE: begin
                    // abort in the same cycle cancels the command
                    if (bus.start && !bus.abort) begin
                        if (bus.len == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state     <= READ;
                            busy_q    <= 1'b1;
                            addr      <= bus.base_addr;
                            remaining <= bus.len;
                        end
                    end
                end
                READ: begin
                    if (rd_go && remaining == AW'(1)) state <= DRAIN;
                end
                DRAIN: begin
                    if (drain_done) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase

            // Abort overrides everything above. DONE is already closing the
            // sweep, so abort there would only produce a second done pulse.
            // Clearing inflight and leaving READ/DRAIN drops any late dval.
            if (bus.abort && active) begin
                state    <= DONE;
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
                inflight <= 1'b0;
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end
        end
    end

    // Credit scheme guarantees a free slot for every returning word.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.dval && active) |-> (count < CW'(DEPTH)));

endmodule
